dma_desc_arb: RTL
=================

DMA_DESC_ARB -- requirements
Module: dma_desc_arb

Interface
REQ-001 Parameter NUM_CH, default 4, SHALL set the number of descriptor requesters (channels).
REQ-002 Parameter DESC_W, default 265, SHALL set the descriptor width; bit DESC_W-1 is the owned-by-hw flag.
REQ-003 Port clk, input, 1: SHALL be the single clock; all logic on rising edge.
REQ-004 Port reset, input, 1: SHALL be an asynchronous, active-high reset.
REQ-005 Port ch_req_i, input, NUM_CH: per-channel request; a descriptor is valid on ch_desc_i.
REQ-006 Port ch_desc_i, input, NUM_CH*DESC_W: per-channel descriptor; channel n occupies slice [n*DESC_W +: DESC_W].
REQ-007 Port ch_en_i, input, NUM_CH: per-channel arbitration enable.
REQ-008 Port ch_ack_o, output, NUM_CH: one-cycle pulse; the descriptor of that channel has been taken.
REQ-009 Port dma_desc_fifo_full_i, input, 1: descriptor-processor FIFO full.
REQ-010 Port dma_desc_fifo_wr_o, output, 1: one-cycle write strobe to the descriptor-processor FIFO.
REQ-011 Port dma_desc_fifo_wrdata_o, output, DESC_W: descriptor written with the strobe.
REQ-012 Port desc_drop_o, output, 1: one-cycle pulse; a granted descriptor was discarded because owned-by-hw = 0.
REQ-013 Port arb_busy_o, output, 1: high whenever the FSM is not in ARB_IDLE.
REQ-014 Port ch_issue_cnt_o, output, NUM_CH*8: per-channel count of descriptors written to the FIFO.

Function
REQ-015 FSM states SHALL be ARB_IDLE, ARB_GRANT and ARB_WRITE.
REQ-016 ARB_IDLE -> ARB_GRANT SHALL occur when dma_desc_fifo_full_i = 0 and (ch_req_i & ch_en_i) != 0; otherwise the FSM stays in ARB_IDLE.
REQ-017 Grant selection in ARB_IDLE SHALL be round-robin: search starts at last_grant+1, modulo NUM_CH, and takes the first eligible channel.
REQ-018 The granted index SHALL be registered on the ARB_IDLE -> ARB_GRANT edge.
REQ-019 ARB_GRANT (exactly 1 cycle) SHALL do three things: latch the granted ch_desc_i slice into desc_reg, assert ch_ack_o[g] only, and set last_grant = g; next state is ARB_WRITE.
REQ-020 In ARB_WRITE with desc_reg[DESC_W-1] = 0, the block SHALL pulse desc_drop_o, leave the counter unchanged, not write, and go to ARB_IDLE.
REQ-021 In ARB_WRITE with the owned bit = 1 and full = 0, the block SHALL assert dma_desc_fifo_wr_o (combinational from state, owned bit and ~full), increment ch_issue_cnt[g], and go to ARB_IDLE.
REQ-022 In ARB_WRITE with the owned bit = 1 and full = 1, the block SHALL hold in ARB_WRITE with the strobe low until full = 0.
REQ-023 dma_desc_fifo_wrdata_o SHALL equal desc_reg at all times.
REQ-024 Latency: with eligible request and FIFO not full in cycle N, the ack SHALL occur in N+1 and the write in N+2; maximum throughput is one descriptor per 3 cycles.
REQ-025 Requester protocol: a requester holds ch_req_i and ch_desc_i stable until ack and deasserts req in the cycle after ack; the arbiter is not required to handle withdrawal before ack.
REQ-026 Deassertion of ch_en_i[g] or ch_req_i[g] after grant SHALL NOT abort the transfer in progress.
REQ-027 Issue counters SHALL be 8-bit and wrap 255 -> 0 without a flag.
REQ-028 Strobe, ack and drop SHALL never overlap; at most one ack bit is high per cycle.

Reset
REQ-029 Reset SHALL force the following: state ARB_IDLE, last_grant = NUM_CH-1 (channel 0 wins first), desc_reg = 0, all counters = 0, all outputs 0.
REQ-030 Reset asserted mid-operation SHALL discard the pending descriptor with no further ack, strobe or drop.

Structure
REQ-031 Package dma_pkg SHALL hold DESC_W, OWN_BIT and the FSM state encodings (3-bit, ARB_IDLE = 0).
REQ-032 The round-robin picker SHALL be a combinational sub-module dma_rr_arb: inputs eligible mask and last_grant, outputs grant index and a valid flag.

Verification
REQ-033 Channels 0..3 request continuously with owned = 1 and FIFO not full -> acks occur in order 0,1,2,3,0 with writes 3 cycles apart; each counter = 1 after the first 4 writes.
REQ-034 Only channel 2 requests with owned bit = 0 -> ack[2] in N+1, desc_drop_o in N+2, no write, cnt[2] = 0.
REQ-035 FSM in ARB_WRITE with full held high for 5 cycles -> no strobe during those 5 cycles; single strobe in the cycle full drops; data unchanged.
REQ-036 ch_en_i = 4'b1011 with all requesting -> channel 2 is never acked.
REQ-037 Channel 1 issues 256 descriptors -> cnt[1] = 0 after wrap.
REQ-038 Reset asserted in ARB_GRANT -> all outputs immediately 0; the first grant after release goes to channel 0.

Source files
------------

// File: rtl/dma_pkg.sv
// Shared constants and FSM encodings for the DMA descriptor arbiter.
package dma_pkg;
   localparam int DESC_W  = 265;
   localparam int OWN_BIT = DESC_W - 1;

   typedef enum logic [2:0] {
      ARB_IDLE  = 3'd0,
      ARB_GRANT = 3'd1,
      ARB_WRITE = 3'd2
   } arb_state_e;
endpackage

// File: rtl/dma_desc_arb_if.sv
// Channel-side request/ack bus plus descriptor-processor FIFO write port.
interface dma_desc_arb_if #(
   parameter int NUM_CH = 4,
   parameter int DESC_W = dma_pkg::DESC_W
);
   logic [NUM_CH-1:0]        ch_req_i;
   logic [NUM_CH*DESC_W-1:0] ch_desc_i;
   logic [NUM_CH-1:0]        ch_en_i;
   logic [NUM_CH-1:0]        ch_ack_o;
   logic                     dma_desc_fifo_full_i;
   logic                     dma_desc_fifo_wr_o;
   logic [DESC_W-1:0]        dma_desc_fifo_wrdata_o;

   modport master (
      input  ch_req_i, ch_desc_i, ch_en_i, dma_desc_fifo_full_i,
      output ch_ack_o, dma_desc_fifo_wr_o, dma_desc_fifo_wrdata_o
   );

   modport slave (
      output ch_req_i, ch_desc_i, ch_en_i, dma_desc_fifo_full_i,
      input  ch_ack_o, dma_desc_fifo_wr_o, dma_desc_fifo_wrdata_o
   );
endinterface

// File: rtl/dma_rr_arb.sv
// Combinational round-robin picker: first eligible channel after last_grant.
module dma_rr_arb import dma_pkg::*; #(
   parameter int NUM_CH = 4,
   parameter int IDX_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
   input  logic [NUM_CH-1:0] eligible,
   input  logic [IDX_W-1:0]  last_grant,
   output logic [IDX_W-1:0]  grant,
   output logic              valid
);
   int c;

   always_comb begin
      grant = '0;
      valid = 1'b0;
      c     = 0;
      for (int i = 1; i <= NUM_CH; i++) begin
         c = (int'(last_grant) + i) % NUM_CH;
         if (!valid && eligible[c]) begin
            valid = 1'b1;
            grant = IDX_W'(c);
         end
      end
   end
endmodule

// File: rtl/dma_desc_arb.sv
// Round-robin descriptor arbiter: grant, latch, then write or drop by owned bit.
module dma_desc_arb import dma_pkg::*; #(
   parameter int NUM_CH = 4,
   parameter int DESC_W = dma_pkg::DESC_W
) (
   input  logic                clk,
   input  logic                reset,
   dma_desc_arb_if.master      bus,
   output logic                desc_drop_o,
   output logic                arb_busy_o,
   output logic [NUM_CH*8-1:0] ch_issue_cnt_o
);
   localparam int IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
   localparam int OWN   = DESC_W - 1;

   arb_state_e               state, nxt;
   logic [IDX_W-1:0]         grant_q, last_grant, pick;
   logic                     pick_vld;
   logic [DESC_W-1:0]        desc_reg;
   logic [NUM_CH-1:0][7:0]   cnt;
   logic [NUM_CH-1:0]        ack;
   logic                     wr, drop;

   dma_rr_arb #(.NUM_CH(NUM_CH), .IDX_W(IDX_W)) u_rr (
      .eligible   (bus.ch_req_i & bus.ch_en_i),
      .last_grant (last_grant),
      .grant      (pick),
      .valid      (pick_vld)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= ARB_IDLE;
      else       state <= nxt;
   end

   // Strobe is combinational so it rises in the same cycle full drops.
   always_comb begin
      nxt  = state;
      ack  = '0;
      wr   = 1'b0;
      drop = 1'b0;
      case (state)
         ARB_IDLE:
            if (!bus.dma_desc_fifo_full_i && pick_vld) nxt = ARB_GRANT;
         ARB_GRANT: begin
            ack[grant_q] = 1'b1;
            nxt          = ARB_WRITE;
         end
         ARB_WRITE:
            if (!desc_reg[OWN]) begin
               drop = 1'b1;
               nxt  = ARB_IDLE;
            end else if (!bus.dma_desc_fifo_full_i) begin
               wr  = 1'b1;
               nxt = ARB_IDLE;
            end
         default: nxt = ARB_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         grant_q    <= '0;
         last_grant <= IDX_W'(NUM_CH - 1);
         desc_reg   <= '0;
         cnt        <= '0;
      end else begin
         if (state == ARB_IDLE && nxt == ARB_GRANT) grant_q <= pick;
         if (state == ARB_GRANT) begin
            desc_reg   <= bus.ch_desc_i[int'(grant_q)*DESC_W +: DESC_W];
            last_grant <= grant_q;
         end
         if (wr) cnt[grant_q] <= cnt[grant_q] + 8'd1;
      end
   end

   assign bus.ch_ack_o               = ack;
   assign bus.dma_desc_fifo_wr_o     = wr;
   assign bus.dma_desc_fifo_wrdata_o = desc_reg;
   assign desc_drop_o                = drop;
   assign arb_busy_o                 = (state != ARB_IDLE);
   assign ch_issue_cnt_o             = cnt;
endmodule
